// File: rtl/hah_audio_pkg.sv
// Shared audio types and channel indices for the FX chain.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hah_audio_pkg;

  localparam int DATA_W = 16;

  // Stereo pair, index 0 = left, index 1 = right.
  typedef logic [1:0][DATA_W-1:0] stereo_sample_t;

  localparam int CH_L = 0;
  localparam int CH_R = 1;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S frame timing: BCLK divider, fall-event tick, bit index and LRCLK.
// Latency: first BCLK fall 2*CLK_DIV clk after reset release.
// Backpressure: none; free-running once out of reset.
module i2s_clkgen #(
  parameter int SLOT_W  = 32,
  parameter int CLK_DIV = 4,
  localparam int B_W    = $clog2(2 * SLOT_W),
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  output logic           i2s_bclk,
  output logic           i2s_lrclk,
  output logic           fall,
  output logic [B_W-1:0] bit_nxt
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [B_W-1:0]   B_LAST   = B_W'(2 * SLOT_W - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [B_W-1:0]   bit_idx;

  // A fall event is the clk on which BCLK is about to go 1 -> 0.
  assign fall    = i2s_bclk && (div_cnt == DIV_LAST);
  assign bit_nxt = (bit_idx == B_LAST) ? '0 : bit_idx + B_W'(1);

  // Divider, bit index and LRCLK; index starts at the last bit so the first fall wraps to 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      i2s_bclk  <= 1'b0;
      bit_idx   <= B_LAST;
      i2s_lrclk <= 1'b0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (fall) begin
        bit_idx   <= bit_nxt;
        i2s_lrclk <= (bit_nxt >= B_W'(SLOT_W));
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: holds the latest stereo sample and serialises it MSB-first, one BCLK after each LRCLK edge.
// Latency: audio_in to left MSB on i2s_dout at most one frame plus one BCLK.
// Backpressure: none; a second sample before the next frame load overwrites the first and flags overrun.
module i2s_tx
  import hah_audio_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SLOT_W  = 32,
  parameter int CLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sample_en,
  input  logic [1:0][DATA_W-1:0] audio_in,
  output logic                   i2s_bclk,
  output logic                   i2s_lrclk,
  output logic                   i2s_dout,
  output logic                   frame_start,
  output logic                   underrun,
  output logic                   overrun
);

  localparam int B_W = $clog2(2 * SLOT_W);

  logic                   fall;
  logic [B_W-1:0]         bit_nxt;
  logic                   load;
  logic                   fresh;
  logic [1:0][DATA_W-1:0] holding;
  logic [1:0][DATA_W-1:0] shift;
  logic                   right_nxt;
  logic [B_W-1:0]         pos;
  logic [DATA_W-1:0]      slot_word;
  logic                   dout_nxt;

  i2s_clkgen #(
    .SLOT_W  (SLOT_W),
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk       (clk),
    .reset_n   (reset_n),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrclk (i2s_lrclk),
    .fall      (fall),
    .bit_nxt   (bit_nxt)
  );

  assign load = fall && (bit_nxt == '0);

  // Pick the bit for the upcoming slot position: pad bit at 0, sample MSB-first, then zeros.
  always_comb begin
    dout_nxt  = 1'b0;
    right_nxt = (bit_nxt >= B_W'(SLOT_W));
    pos       = right_nxt ? (bit_nxt - B_W'(SLOT_W)) : bit_nxt;
    slot_word = right_nxt ? shift[CH_R] : shift[CH_L];
    for (int k = 1; k <= DATA_W; k++) begin
      if (pos == B_W'(k)) dout_nxt = slot_word[DATA_W-k];
    end
  end

  // Holding/shift registers, fresh tracking and single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      holding     <= '0;
      shift       <= '0;
      fresh       <= 1'b0;
      i2s_dout    <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
      if (fall) i2s_dout <= dout_nxt;
      if (load) begin
        frame_start <= 1'b1;
        fresh       <= 1'b0;
        if (sample_en) begin
          // Sample arriving on the load clk goes straight into this frame.
          shift   <= audio_in;
          holding <= audio_in;
        end else begin
          shift    <= holding;
          underrun <= ~fresh;
        end
      end else if (sample_en) begin
        holding <= audio_in;
        fresh   <= 1'b1;
        overrun <= fresh;
      end
    end
  end

endmodule
